// File: rtl/ps2_frame_receiver.sv
// PS/2 receive deserialiser: start, 8 data bits LSB first, odd parity, stop.
// Ports: CLOCK_50/reset (async, active-high); PS2_CLK/PS2_DAT raw pins in;
//   key_data last good byte; byte_valid, frame_error, parity_error pulses; busy.
// Optional: PS2_PARITY_CHECK_EN enables parity checking and parity_error.
module ps2_frame_receiver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TIMEOUT_US  = 2000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] key_data,
  output logic       byte_valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILTER_LEN);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_s, dat_s;
  logic filt_q, filt_prev_q, fall;
  logic [FW-1:0] fcnt_q;
  logic [TW-1:0] tmo_q;
  logic tmo_hit;
  logic [7:0] shift_q;
  logic [2:0] bitcnt_q;
  logic bv_d, fe_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Count samples that disagree with the filtered level; any
  // agreeing sample restarts the run, so short glitches vanish.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= clk_s;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (fall || state_q == IDLE) begin
      tmo_q <= '0;
    end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Fires on the edge where the counter reaches TIMEOUT_CYC;
  // a coincident fall takes precedence.
  assign tmo_hit = (state_q != IDLE) && !fall &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_ok, pe_d;
  assign par_ok = ^{shift_q, par_q};
`endif

  always_comb begin
    state_d = state_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    pe_d    = 1'b0;
`endif
    if (fall) begin
      unique case (state_q)
        IDLE:   if (!dat_s) state_d = DATA;
        DATA:   if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (!dat_s) fe_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (!par_ok) pe_d = 1'b1;
`endif
          else bv_d = 1'b1;
        end
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
      fe_d    = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      bitcnt_q    <= '0;
      key_data    <= '0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= bv_d;
      frame_error <= fe_d;
      if (bv_d) key_data <= shift_q;
      if (fall && state_q == IDLE) bitcnt_q <= '0;
      if (fall && state_q == DATA) begin
        shift_q  <= {dat_s, shift_q[7:1]};
        bitcnt_q <= bitcnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      par_q        <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= pe_d;
      if (fall && state_q == PARITY) par_q <= dat_s;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  assign busy = (state_q != IDLE);

endmodule
